// File: rtl/rf_dump_pkg.sv
// Shared definitions for the register-file debug dumper:
// FSM encoding, record length and byte-lane selectors.
package rf_dump_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEL,
        S_SEND,
        S_NEXT,
        S_DONE
    } state_e;

    localparam int unsigned REC_BYTES = 5;
    localparam int unsigned CNTW      = 3;

    // Byte position within a record: index byte first, then data MSB to LSB.
    localparam logic [CNTW-1:0] BSEL_IDX  = CNTW'(0);
    localparam logic [CNTW-1:0] BSEL_B3   = CNTW'(1);
    localparam logic [CNTW-1:0] BSEL_B2   = CNTW'(2);
    localparam logic [CNTW-1:0] BSEL_B1   = CNTW'(3);
    localparam logic [CNTW-1:0] BSEL_B0   = CNTW'(4);
    localparam logic [CNTW-1:0] BSEL_LAST = CNTW'(REC_BYTES - 1);

endpackage

// File: rtl/rf_dump.sv
// Scans registers 1..NREG-1 through the register file debug port and
// streams each one as a 5-byte {idx, data[31:0]} record on a valid/ready byte bus.
module rf_dump #(
    parameter int unsigned NREG      = 32,
    parameter int unsigned IDXW      = 5,
    parameter bit          SKIP_ZERO = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    output logic            busy,
    output logic            done,
    output logic [IDXW-1:0] reg_sel,
    input  logic [31:0]     reg_data,
    output logic [7:0]      tx_data,
    output logic            tx_valid,
    input  logic            tx_ready
);
    import rf_dump_pkg::*;

    state_e            state_q,    state_d;
    logic [IDXW-1:0]   idx_q,      idx_d;
    logic [CNTW-1:0]   byte_cnt_q, byte_cnt_d;
    logic [31:0]       shadow_q,   shadow_d;
    logic              abort_q,    abort_d;
    logic [IDXW-1:0]   reg_sel_q,  reg_sel_d;
    logic              busy_q,     busy_d;
    logic              done_q,     done_d;
    logic              tx_valid_q, tx_valid_d;
    logic [7:0]        tx_data_q,  tx_data_d;
    logic              accept_c;

    function automatic logic [7:0] lane(input logic [31:0]     word,
                                        input logic [IDXW-1:0] idx,
                                        input logic [CNTW-1:0] sel);
        case (sel)
            BSEL_IDX: lane = 8'(idx);
            BSEL_B3:  lane = word[31:24];
            BSEL_B2:  lane = word[23:16];
            BSEL_B1:  lane = word[15:8];
            BSEL_B0:  lane = word[7:0];
            default:  lane = 8'h00;
        endcase
    endfunction

    assign accept_c = tx_valid_q && tx_ready;

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        byte_cnt_d = byte_cnt_q;
        shadow_d   = shadow_q;
        abort_d    = abort_q;
        reg_sel_d  = reg_sel_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_SEL;
                    idx_d     = IDXW'(1);
                    reg_sel_d = IDXW'(1);
                    busy_d    = 1'b1;
                    abort_d   = 1'b0;
                end
            end
            S_SEL: begin
                if (abort) begin
                    state_d   = S_IDLE;
                    busy_d    = 1'b0;
                    reg_sel_d = '0;
                end else begin
                    shadow_d = reg_data;
                    if (SKIP_ZERO && (reg_data == 32'h0)) begin
                        state_d = S_NEXT;
                    end else begin
                        state_d    = S_SEND;
                        tx_valid_d = 1'b1;
                        tx_data_d  = lane(reg_data, idx_q, BSEL_IDX);
                        byte_cnt_d = BSEL_IDX;
                    end
                end
            end
            S_SEND: begin
                // An abort seen while stalled is remembered until the held byte drains.
                if (accept_c) begin
                    if (abort || abort_q) begin
                        tx_valid_d = 1'b0;
                        state_d    = S_IDLE;
                        busy_d     = 1'b0;
                        reg_sel_d  = '0;
                        abort_d    = 1'b0;
                    end else if (byte_cnt_q == BSEL_LAST) begin
                        tx_valid_d = 1'b0;
                        state_d    = S_NEXT;
                    end else begin
                        byte_cnt_d = byte_cnt_q + CNTW'(1);
                        tx_data_d  = lane(shadow_q, idx_q, byte_cnt_q + CNTW'(1));
                    end
                end else if (abort) begin
                    abort_d = 1'b1;
                end
            end
            S_NEXT: begin
                if (abort) begin
                    state_d   = S_IDLE;
                    busy_d    = 1'b0;
                    reg_sel_d = '0;
                end else if (idx_q == IDXW'(NREG - 1)) begin
                    state_d = S_DONE;
                end else begin
                    idx_d     = idx_q + IDXW'(1);
                    reg_sel_d = idx_q + IDXW'(1);
                    state_d   = S_SEL;
                end
            end
            S_DONE: begin
                done_d    = 1'b1;
                busy_d    = 1'b0;
                reg_sel_d = '0;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            byte_cnt_q <= '0;
            shadow_q   <= '0;
            abort_q    <= 1'b0;
            reg_sel_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            byte_cnt_q <= byte_cnt_d;
            shadow_q   <= shadow_d;
            abort_q    <= abort_d;
            reg_sel_q  <= reg_sel_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign reg_sel  = reg_sel_q;
    assign tx_valid = tx_valid_q;
    assign tx_data  = tx_data_q;

endmodule

// File: tb/tb_rf_dump.sv
// Scoreboard bench for rf_dump: two instances (SKIP_ZERO=0 and 1) read a shared
// register-file model; expected bytes come from a record-level reference model.
module tb_rf_dump;
    localparam int unsigned NREG = 32;
    localparam int unsigned IDXW = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] rf      [NREG];
    logic [31:0] exp_img [NREG];

    logic            start0 = 1'b0, start1 = 1'b0, abort0 = 1'b0;
    logic            busy0, done0, tv0, busy1, done1, tv1;
    logic [IDXW-1:0] sel0, sel1;
    logic [7:0]      td0, td1;
    logic [31:0]     rd0, rd1;
    logic            ready0;
    int              rmode     = 0;
    logic            man_ready = 1'b1;
    logic            rnd_bit   = 1'b1;

    assign rd0    = (sel0 == '0) ? 32'h0 : rf[sel0];
    assign rd1    = (sel1 == '0) ? 32'h0 : rf[sel1];
    assign ready0 = (rmode == 1) ? rnd_bit : (rmode == 2) ? man_ready : 1'b1;

    rf_dump #(.NREG(NREG), .IDXW(IDXW), .SKIP_ZERO(1'b0)) dut_a (
        .clk(clk), .rst(rst), .start(start0), .abort(abort0),
        .busy(busy0), .done(done0), .reg_sel(sel0), .reg_data(rd0),
        .tx_data(td0), .tx_valid(tv0), .tx_ready(ready0)
    );

    rf_dump #(.NREG(NREG), .IDXW(IDXW), .SKIP_ZERO(1'b1)) dut_b (
        .clk(clk), .rst(rst), .start(start1), .abort(1'b0),
        .busy(busy1), .done(done1), .reg_sel(sel1), .reg_data(rd1),
        .tx_data(td1), .tx_valid(tv1), .tx_ready(1'b1)
    );

    always @(posedge clk) begin
        #1;
        rnd_bit = ($urandom() % 2) != 0;
    end

    logic [7:0] sb0 [$];
    logic [7:0] sb1 [$];
    int checks = 0, errs = 0;
    int acc0 = 0, acc1 = 0, dcnt0 = 0, dcnt1 = 0;
    logic       pv0 = 1'b0, pr0 = 1'b0;
    logic [7:0] pd0 = 8'h00;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errs++;
            $display("FAIL %s: got %h, expected %h", nm, act, expv);
        end
    endtask

    // Monitor: a byte is taken when valid && ready is seen ahead of the rising edge.
    always @(negedge clk) begin
        if (rst) begin
            pv0 = 1'b0;
        end else begin
            if (pv0 && !pr0) begin
                chk("stall_valid_a", 32'(tv0), 32'd1);
                chk("stall_data_a", 32'(td0), 32'(pd0));
            end
            if (tv0 && ready0) begin
                acc0++;
                checks++;
                if (sb0.size() == 0) begin
                    errs++;
                    $display("FAIL extra_byte_a: got %h, expected no byte", td0);
                end else if (td0 !== sb0[0]) begin
                    errs++;
                    $display("FAIL stream_a byte %0d: got %h, expected %h", acc0, td0, sb0[0]);
                    void'(sb0.pop_front());
                end else begin
                    void'(sb0.pop_front());
                end
            end
            if (tv1) begin
                acc1++;
                checks++;
                if (sb1.size() == 0) begin
                    errs++;
                    $display("FAIL extra_byte_b: got %h, expected no byte", td1);
                end else if (td1 !== sb1[0]) begin
                    errs++;
                    $display("FAIL stream_b byte %0d: got %h, expected %h", acc1, td1, sb1[0]);
                    void'(sb1.pop_front());
                end else begin
                    void'(sb1.pop_front());
                end
            end
            if (done0) begin
                dcnt0++;
                chk("busy_low_at_done_a", 32'(busy0), 32'd0);
            end
            if (done1) begin
                dcnt1++;
                chk("busy_low_at_done_b", 32'(busy1), 32'd0);
            end
            pv0 = tv0;
            pr0 = ready0;
            pd0 = td0;
        end
    end

    // Reference model: one record per register, optionally skipping zeros, truncated to limit.
    task automatic push_expected(input bit to_b, input bit skip, input int limit);
        int n;
        n = 0;
        for (int r = 1; r < NREG; r++) begin
            if (skip && exp_img[r] == 32'h0) continue;
            for (int b = 0; b < 5; b++) begin
                logic [7:0] v;
                v = (b == 0) ? 8'(r) : 8'((exp_img[r] >> (8 * (4 - b))) & 32'hFF);
                if (limit < 0 || n < limit) begin
                    if (to_b) sb1.push_back(v);
                    else      sb0.push_back(v);
                end
                n++;
            end
        end
    endtask

    task automatic pulse_start(input bit b);
        @(negedge clk);
        if (b) start1 = 1'b1;
        else   start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic wait_done(input bit b, input int budget, output int n);
        n = 0;
        while (1) begin
            @(posedge clk);
            #1;
            n++;
            if ((b ? done1 : done0) === 1'b1) break;
            if (n >= budget) begin
                checks++;
                errs++;
                $display("FAIL done_timeout: waited %0d cycles, expected done within %0d", n, budget);
                break;
            end
        end
    endtask

    task automatic randomize_rf();
        rf[0] = 32'h0;
        for (int r = 1; r < NREG; r++) rf[r] = $urandom();
    endtask

    initial begin
        int n, dsave;
        logic [31:0] old2;
        bit hit;

        for (int r = 0; r < NREG; r++) rf[r] = 32'h0;
        rf[1]  = 32'h1234_5678;
        rf[31] = 32'hDEAD_BEEF;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_done", 32'(done0), 32'd0);
        chk("rst_valid", 32'(tv0), 32'd0);
        chk("rst_data", 32'(td0), 32'd0);
        chk("rst_sel", 32'(sel0), 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;

        // Full dump with ready high; check first-record latency and total length.
        exp_img = rf;
        push_expected(1'b0, 1'b0, -1);
        acc0 = 0;
        pulse_start(1'b0);
        chk("s1_sel_after_start", 32'(sel0), 32'd1);
        chk("s1_busy_after_start", 32'(busy0), 32'd1);
        chk("s1_valid_in_sel", 32'(tv0), 32'd0);
        wait_done(1'b0, 400, n);
        chk("s1_cycles_to_done", 32'(n), 32'd218);
        repeat (2) @(posedge clk);
        #1;
        chk("s1_bytes", 32'(acc0), 32'd155);
        chk("s1_queue_empty", 32'(sb0.size()), 32'd0);
        chk("s1_done_count", 32'(dcnt0), 32'd1);

        // SKIP_ZERO instance with the same contents.
        exp_img = rf;
        push_expected(1'b1, 1'b1, -1);
        pulse_start(1'b1);
        wait_done(1'b1, 400, n);
        repeat (2) @(posedge clk);
        #1;
        chk("s2_bytes", 32'(acc1), 32'd10);
        chk("s2_queue_empty", 32'(sb1.size()), 32'd0);
        chk("s2_done_count", 32'(dcnt1), 32'd1);

        // Random backpressure.
        exp_img = rf;
        push_expected(1'b0, 1'b0, -1);
        acc0 = 0;
        rmode = 1;
        pulse_start(1'b0);
        wait_done(1'b0, 2000, n);
        rmode = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("s3_bytes", 32'(acc0), 32'd155);
        chk("s3_queue_empty", 32'(sb0.size()), 32'd0);
        chk("s3_done_count", 32'(dcnt0), 32'd2);

        // Abort while record 3 byte 2 is stalled.
        randomize_rf();
        exp_img = rf;
        push_expected(1'b0, 1'b0, 13);
        acc0 = 0;
        dsave = dcnt0;
        man_ready = 1'b1;
        rmode = 2;
        pulse_start(1'b0);
        hit = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #2;
            if (acc0 == 12) begin
                hit = 1'b1;
                break;
            end
        end
        chk("s4_reached_byte12", 32'(hit), 32'd1);
        man_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        abort0 = 1'b1;
        @(posedge clk);
        #2;
        abort0 = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("s4_still_valid", 32'(tv0), 32'd1);
        man_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("s4_valid_low", 32'(tv0), 32'd0);
        chk("s4_busy_low", 32'(busy0), 32'd0);
        chk("s4_sel_zero", 32'(sel0), 32'd0);
        chk("s4_bytes", 32'(acc0), 32'd13);
        chk("s4_queue_empty", 32'(sb0.size()), 32'd0);
        chk("s4_no_done", 32'(dcnt0), 32'(dsave));
        rmode = 0;

        // Second start mid-dump is ignored; async reset mid-SEND; then a clean dump.
        randomize_rf();
        exp_img = rf;
        push_expected(1'b0, 1'b0, -1);
        pulse_start(1'b0);
        repeat (40) @(posedge clk);
        pulse_start(1'b0);
        hit = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (tv0) begin
                hit = 1'b1;
                break;
            end
        end
        chk("s5_in_send", 32'(hit), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("s5_rst_busy", 32'(busy0), 32'd0);
        chk("s5_rst_valid", 32'(tv0), 32'd0);
        chk("s5_rst_data", 32'(td0), 32'd0);
        chk("s5_rst_sel", 32'(sel0), 32'd0);
        chk("s5_rst_done", 32'(done0), 32'd0);
        sb0.delete();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        exp_img = rf;
        push_expected(1'b0, 1'b0, -1);
        acc0 = 0;
        dsave = dcnt0;
        pulse_start(1'b0);
        wait_done(1'b0, 400, n);
        repeat (2) @(posedge clk);
        #1;
        chk("s5_bytes", 32'(acc0), 32'd155);
        chk("s5_queue_empty", 32'(sb0.size()), 32'd0);
        chk("s5_done_count", 32'(dcnt0), 32'(dsave + 1));

        // Writes during the dump: r5 not yet sampled, r2 already sampled.
        randomize_rf();
        old2 = rf[2];
        exp_img = rf;
        exp_img[5] = 32'hA5A5_A5A5;
        push_expected(1'b0, 1'b0, -1);
        acc0 = 0;
        pulse_start(1'b0);
        hit = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (sel0 == IDXW'(3)) begin
                hit = 1'b1;
                break;
            end
        end
        chk("s6_reached_idx3", 32'(hit), 32'd1);
        rf[5] = 32'hA5A5_A5A5;
        rf[2] = ~old2;
        wait_done(1'b0, 400, n);
        repeat (2) @(posedge clk);
        #1;
        chk("s6_bytes", 32'(acc0), 32'd155);
        chk("s6_queue_empty", 32'(sb0.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
        $finish;
    end

endmodule

// File: doc/rf_dump.md
Name: rf_dump

Overview:
- Debug reader for the CPU register file's read-only debug port (`reg_sel` / `reg_data`).
- On a start pulse, scans registers 1..NREG-1 and samples each one.
- Serialises each register as a 5-byte record on a valid/ready byte stream for a downstream UART transmitter or trace buffer.
- Sits beside the register file in the multi-cycle CPU top level. It never writes the register file.

Parameters:
- NREG, 32, number of architectural registers scanned (indices 0..NREG-1; index 0 is never emitted).
- IDXW, 5, width of the register index; must satisfy 2**IDXW >= NREG and IDXW <= 8.
- SKIP_ZERO, 0, when 1, registers whose sampled value is 0 emit no record.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to begin a dump; honoured only in IDLE.
- abort  input  1  request to stop the dump early; honoured at a byte boundary.
- busy  output  1  high from the cycle after start is accepted until the dump ends.
- done  output  1  one-cycle pulse when a dump completes normally; not pulsed on abort.
- reg_sel  output  IDXW  register index driven to the register file's debug port.
- reg_data  input  32  combinational register-file read of reg_sel (reads 0 when reg_sel == 0).
- tx_data  output  8  stream byte.
- tx_valid  output  1  stream byte valid.
- tx_ready  input  1  downstream accepts the byte when tx_valid && tx_ready at a rising edge.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, reg_sel=0, busy=0, done=0, tx_valid=0, tx_data=0, idx=0, byte_cnt=0, shadow=0.
- All outputs are registered.
- FSM states:
  - IDLE: on start, go to SEL with idx=1, reg_sel<=1, busy<=1.
  - SEL: reg_sel has been stable for the whole cycle. Capture shadow<=reg_data at the end of the cycle.
    - If SKIP_ZERO==1 and reg_data==0, go to NEXT.
    - Otherwise go to SEND with tx_valid<=1, tx_data<={(8-IDXW)'b0, idx}, byte_cnt<=0.
  - SEND: the byte is held stable while tx_valid && !tx_ready. On acceptance:
    - byte_cnt 0..3: load the next byte (shadow[31:24], [23:16], [15:8], [7:0] for bytes 1..4).
    - byte_cnt 4: tx_valid<=0, go to NEXT.
  - NEXT:
    - If idx==NREG-1, go to DONE.
    - Otherwise idx<=idx+1, reg_sel<=idx+1, go to SEL.
  - DONE: done<=1 for one cycle, busy<=0, reg_sel<=0, return to IDLE.
- Latency: start sampled at edge E0. reg_sel=1 is visible after E0. The first tx_valid is visible after E1.
  - With tx_ready tied high and SKIP_ZERO=0, each record costs 7 cycles (SEL, 5 SEND, NEXT).
  - The total dump is 31*7+1 cycles before done for NREG=32.
- Record format: {idx, data[31:24], data[23:16], data[15:8], data[7:0]}. The idx byte is zero-extended.
- Each register's value is sampled exactly once, during its SEL cycle. Register-file writes during a dump are visible only for registers not yet sampled, so a dump is not an atomic snapshot.
- start while busy or in DONE is ignored and is not queued.
- abort:
  - In SEL or NEXT: go to IDLE next edge, busy<=0, reg_sel<=0, no done.
  - In SEND with tx_valid && !tx_ready: the current byte stays valid until accepted, then go to IDLE. The abort request is latched, so abort may be a single-cycle pulse.
  - In SEND when the byte is accepted the same cycle: go to IDLE immediately.
  - In IDLE: ignored. Simultaneous start and abort in IDLE starts the dump.
- tx_ready low indefinitely: the block stalls in SEND with stable outputs; no timeout.
- idx arithmetic is IDXW bits wide. There is no wrap, because termination is checked before the increment.

Decomposition:
- Shared package: FSM state encoding (IDLE, SEL, SEND, NEXT, DONE), the record length constant REC_BYTES=5, and the byte-select constants.
- No sub-module. A byte-lane mux function inside rf_dump is sufficient.

Test Plan:
- Load r1=0x12345678, r31=0xDEADBEEF, others 0; tx_ready=1; pulse start -> 155 bytes. The first record is 01 12 34 56 78, the last is 1F DE AD BE EF. done pulses once, and busy is low on the same cycle done is high.
- SKIP_ZERO=1 with the same contents -> exactly 10 bytes: 01 12 34 56 78 1F DE AD BE EF, then done.
- Random tx_ready backpressure (50%) -> byte sequence identical to scenario 1; tx_data is stable whenever tx_valid && !tx_ready.
- Pulse abort while byte 2 of record 3 is stalled -> that byte (0x??, r3[23:16]) is still delivered once. Then tx_valid=0, busy=0, reg_sel=0, and no done pulse.
- Pulse start again mid-dump, and assert rst asynchronously mid-SEND -> the second start has no effect. On reset, all outputs go to reset values immediately; a new start afterwards yields a full, correct dump.
- Write r5=0xA5A5A5A5 via RFWr while the dump is at idx 3 -> record 5 carries A5 A5 A5 A5. A write to r2 after it was sampled does not appear in the dump.
